// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the keypad calculator controller.
// Holds key codes, operator encoding, FSM state encoding, the result width
// and small key-classification / decimal-accumulate helpers.
package calc_pkg;

    localparam int RESULT_W = 6;

    localparam logic [3:0] KEY_PLUS  = 4'hA;
    localparam logic [3:0] KEY_MINUS = 4'hB;
    localparam logic [3:0] KEY_EQ    = 4'hE;
    localparam logic [3:0] KEY_CLR   = 4'hF;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10
    } op_e;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        OP_WAIT = 3'd1,
        ENTER_B = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4,
        ERROR   = 3'd5
    } state_e;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] key);
        return (key == KEY_PLUS) || (key == KEY_MINUS);
    endfunction

    function automatic op_e key_to_op(input logic [3:0] key);
        return (key == KEY_MINUS) ? OP_SUB : OP_ADD;
    endfunction

    // value*10 + d, kept 8 bits wide so an entry past 15 is visible to the caller.
    function automatic logic [7:0] mul10_add(input logic [3:0] value, input logic [3:0] d);
        logic [7:0] v;
        v = {4'b0000, value};
        return (v << 3) + (v << 1) + {4'b0000, d};
    endfunction

endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational add/subtract of two 4-bit unsigned operands.
// Ports:
//   a  [3:0]          operand A
//   b  [3:0]          operand B
//   op                operator (none/add/sub)
//   r  [RESULT_W-1:0] signed result, A+B or A-B; passes A through for none
module calc_alu
    import calc_pkg::*;
(
    input  logic        [3:0]          a,
    input  logic        [3:0]          b,
    input  op_e                        op,
    output logic signed [RESULT_W-1:0] r
);

    logic [RESULT_W-1:0] a_ext;
    logic [RESULT_W-1:0] b_ext;

    assign a_ext = {2'b00, a};
    assign b_ext = {2'b00, b};

    // Operands are zero-extended, so the 6-bit result spans -15..30 without overflow.
    always_comb begin
        case (op)
            OP_ADD:  r = a_ext + b_ext;
            OP_SUB:  r = a_ext - b_ext;
            default: r = a_ext;
        endcase
    end

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad sequencer for the 4-bit calculator datapath.
// Collects operand A, operator and operand B from key strobes, runs one
// add/subtract in a dedicated execute cycle and holds the result for display.
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous active-high reset
//   KEY_VALID  one-cycle key strobe, honoured only while KEY_READY=1
//   KEY_CODE   0-9 digit, A '+', B '-', E '=', F clear, others ignored
//   KEY_READY  low during the execute cycle
//   DISP_DATA  two's-complement value to display
//   OP_SEL     stored operator (00 none, 01 add, 10 sub)
//   ERR        error flag, cleared only by clear or reset
//
// state   | meaning
// --------+-----------------------------------------------
// ENTER_A | accumulating operand A, display shows A
// OP_WAIT | operator stored, waiting for first B digit
// ENTER_B | accumulating operand B, display shows B
// EXEC    | one-cycle compute, keys dropped
// SHOW    | result R displayed, chain / repeat '=' allowed
// ERROR   | entry or chaining out of range, only clear exits
module calc_ctrl
    import calc_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                KEY_VALID,
    input  logic [3:0]          KEY_CODE,
    output logic                KEY_READY,
    output logic [RESULT_W-1:0] DISP_DATA,
    output logic [1:0]          OP_SEL,
    output logic                ERR
);

    state_e                     state, state_nx;
    logic [3:0]                 a_q, a_nx;
    logic [3:0]                 b_q, b_nx;
    logic signed [RESULT_W-1:0] r_q, r_nx;
    op_e                        op_q, op_nx;
    logic [RESULT_W-1:0]        disp_q, disp_nx;

    logic signed [RESULT_W-1:0] alu_r;
    logic                       key_acc;
    logic [7:0]                 acc_a;
    logic [7:0]                 acc_b;
    logic                       r_in_range;

    calc_alu u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .r  (alu_r)
    );

    assign key_acc    = KEY_VALID && (state != EXEC);
    assign acc_a      = mul10_add(a_q, KEY_CODE);
    assign acc_b      = mul10_add(b_q, KEY_CODE);
    // 0..15 exactly when the two top bits of the signed result are clear.
    assign r_in_range = (r_q[RESULT_W-1:4] == 2'b00);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= ENTER_A;
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            op_q   <= OP_NONE;
            disp_q <= '0;
        end else begin
            state  <= state_nx;
            a_q    <= a_nx;
            b_q    <= b_nx;
            r_q    <= r_nx;
            op_q   <= op_nx;
            disp_q <= disp_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        b_nx     = b_q;
        r_nx     = r_q;
        op_nx    = op_q;
        disp_nx  = disp_q;

        if (state == EXEC) begin
            r_nx     = alu_r;
            disp_nx  = alu_r;
            state_nx = SHOW;
        end else if (key_acc) begin
            if (KEY_CODE == KEY_CLR) begin
                state_nx = ENTER_A;
                a_nx     = '0;
                b_nx     = '0;
                r_nx     = '0;
                op_nx    = OP_NONE;
                disp_nx  = '0;
            end else begin
                case (state)
                    ENTER_A: begin
                        if (is_digit(KEY_CODE)) begin
                            if (acc_a > 8'd15) begin
                                state_nx = ERROR;
                                disp_nx  = '0;
                            end else begin
                                a_nx    = acc_a[3:0];
                                disp_nx = {2'b00, acc_a[3:0]};
                            end
                        end else if (is_op(KEY_CODE)) begin
                            op_nx    = key_to_op(KEY_CODE);
                            state_nx = OP_WAIT;
                        end
                    end
                    OP_WAIT: begin
                        if (is_digit(KEY_CODE)) begin
                            b_nx     = KEY_CODE;
                            disp_nx  = {2'b00, KEY_CODE};
                            state_nx = ENTER_B;
                        end else if (is_op(KEY_CODE)) begin
                            op_nx = key_to_op(KEY_CODE);
                        end
                    end
                    ENTER_B: begin
                        if (is_digit(KEY_CODE)) begin
                            if (acc_b > 8'd15) begin
                                state_nx = ERROR;
                                disp_nx  = '0;
                            end else begin
                                b_nx    = acc_b[3:0];
                                disp_nx = {2'b00, acc_b[3:0]};
                            end
                        end else if (KEY_CODE == KEY_EQ) begin
                            state_nx = EXEC;
                        end
                    end
                    SHOW: begin
                        if (is_digit(KEY_CODE)) begin
                            a_nx     = KEY_CODE;
                            b_nx     = '0;
                            op_nx    = OP_NONE;
                            disp_nx  = {2'b00, KEY_CODE};
                            state_nx = ENTER_A;
                        end else if (is_op(KEY_CODE) || (KEY_CODE == KEY_EQ)) begin
                            if (r_in_range) begin
                                a_nx = r_q[3:0];
                                if (KEY_CODE == KEY_EQ) begin
                                    state_nx = EXEC;
                                end else begin
                                    op_nx    = key_to_op(KEY_CODE);
                                    state_nx = OP_WAIT;
                                end
                            end else begin
                                state_nx = ERROR;
                                disp_nx  = '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        KEY_READY = (state != EXEC);
        ERR       = (state == ERROR);
        DISP_DATA = disp_q;
        OP_SEL    = op_q;
    end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Keypad-driven sequencer for the 4-bit calculator datapath. Collects decimal operand A, an operator (+/−) and operand B from one-cycle key strobes, then runs one add/subtract in a dedicated execute cycle. Registers the signed result for display and supports chained operations and repeated '='. Sits between the key-input decoder and the display driver; owns all operand/result state of the calc block.

## Interface
Parameters: none (widths fixed: 4-bit operands, 6-bit signed result).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- KEY_VALID  in  1  one-cycle key strobe; sampled only when KEY_READY=1.
- KEY_CODE  in  4  key: 0x0–0x9 digit, 0xA '+', 0xB '−', 0xE '=', 0xF clear; other codes ignored.
- KEY_READY  out  1  low during the execute cycle; keys then are dropped.
- DISP_DATA  out  6  two's-complement value to display.
- OP_SEL  out  2  stored operator: 00 none, 01 add, 10 sub.
- ERR  out  1  sticky error flag.

## Operation
- Reset (async): state ENTER_A, A=B=0, R=0, op=none; DISP_DATA=0, OP_SEL=00, ERR=0, KEY_READY=1.
- Digit entry: value ← value×10 + d. Result >15 → ERROR.
- States/transitions (accepted key only):
  - ENTER_A: digit → accumulate A. op → store op, OP_WAIT. '=' ignored. Shows A.
  - OP_WAIT: digit → B=d, ENTER_B. op → replace op. '=' ignored. Shows A.
  - ENTER_B: digit → accumulate B. '=' → EXEC. op ignored. Shows B.
  - EXEC: one cycle, KEY_READY=0. R ← A+B (add) or A−B (sub), zero-extended to 6 bits. → SHOW.
  - SHOW: shows R.
    - digit → A=d, B=0, op=none, ENTER_A.
    - op → if 0≤R≤15: A=R[3:0], op stored, OP_WAIT; else ERROR.
    - '=' → if 0≤R≤15: A=R[3:0], B unchanged, EXEC; else ERROR.
  - ERROR: ERR=1, DISP_DATA=0; only clear exits.
- Clear (0xF) in any state except EXEC: identical to reset values, synchronous.
- Arithmetic range: R ∈ [−15, 30], no overflow possible in 6 bits.

## Timing
- All outputs registered. They update on the edge that samples the key.
- '=' sampled at edge n:
  - edge n: state=EXEC, KEY_READY=0.
  - edge n+1: DISP_DATA=R, state=SHOW, KEY_READY=1.
  - Key-to-result latency: 2 cycles. KEY_READY low for exactly one cycle.
- KEY_VALID while KEY_READY=0 is dropped: no state or output change, no buffering.
- Back-to-back keys on consecutive cycles are accepted whenever KEY_READY=1.
- RESET mid-operation: outputs go to reset values immediately (asynchronous). The first key is accepted on the first edge after release.

## Structure
- Shared package calc_pkg:
  - key code constants.
  - op encoding (none/add/sub).
  - state enum (ENTER_A, OP_WAIT, ENTER_B, EXEC, SHOW, ERROR).
  - RESULT_W=6.
- Sub-module calc_alu: combinational. Inputs A[3:0], B[3:0], op. Output R[5:0] signed. Built from the existing adder/subtractor cells.
- calc_ctrl holds the FSM, the A/B/R/op registers and the decimal accumulator.

## Test plan
- Reset; keys 7,'+',5,'=':
  - OP_SEL=01 after '+'.
  - KEY_READY low one cycle.
  - DISP_DATA=12 two edges after '='.
- Keys 3,'−',9,'=': DISP_DATA=6'b111010 (−6), OP_SEL=10.
- Entry overflow:
  - Keys 1,5 → DISP_DATA=15.
  - Then 1,6 sequence from clear → 16 → ERR=1, DISP_DATA=0.
  - Further digits ignored.
  - Clear → ERR=0, DISP_DATA=0, ENTER_A.
- Chaining:
  - Keys 9,'+',6,'=' → 15.
  - Then '−',4,'=' → 11.
  - Then '=' → 7.
  - Then '=' → 3.
- Out-of-range chaining: keys 15,'+',15,'=' → DISP_DATA=30; then '+' → ERR=1.
- Key strobe during EXEC is ignored (result unchanged). RESET asserted mid-ENTER_B forces all outputs to reset values before the next clock edge.
